// File: rtl/pfxsum_ctrl.sv
// Prefix-sum job controller: streams V_LEN-element vectors from source memory into an
// external prefix-sum unit and writes each result vector back to destination memory.
module pfxsum_ctrl #(
  parameter int IWIDTH  = 8,
  parameter int V_LEN   = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AWIDTH-1:0]        src_addr,
  input  logic [AWIDTH-1:0]        dst_addr,
  input  logic [AWIDTH-1:0]        num_vec,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     rd_en,
  output logic [AWIDTH-1:0]        rd_addr,
  input  logic [IWIDTH-1:0]        rd_data,
  output logic                     wr_en,
  output logic [AWIDTH-1:0]        wr_addr,
  output logic [IWIDTH-1:0]        wr_data,
  output logic                     pfx_valid_in,
  output logic [IWIDTH*V_LEN-1:0]  pfx_ivec,
  input  logic                     pfx_valid_out,
  input  logic [IWIDTH*V_LEN-1:0]  pfx_ovec
);

  localparam int IDXW = (V_LEN > 1) ? $clog2(V_LEN) : 1;
  localparam int TOW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, ISSUE, WAIT, STORE, DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [AWIDTH-1:0]         r_rdPtr;
  logic [AWIDTH-1:0]         r_wrPtr;
  logic [AWIDTH-1:0]         r_numVec;
  logic [AWIDTH-1:0]         r_vecCnt;
  logic [IDXW-1:0]           r_idx;
  logic [IDXW-1:0]           r_capIdx;
  logic                      r_capValid;
  logic [TOW-1:0]            r_toCnt;
  logic                      r_err;
  logic [IWIDTH*V_LEN-1:0]   r_lanes;
  logic [IWIDTH*V_LEN-1:0]   r_result;
  logic                      w_lastIdx;
  logic                      w_lastVec;
  logic                      w_timeout;
  logic [AWIDTH-1:0]         w_vecNext;

  assign w_lastIdx = (r_idx == IDXW'(V_LEN - 1));
  assign w_vecNext = r_vecCnt + AWIDTH'(1);
  assign w_lastVec = (w_vecNext == r_numVec);
  assign w_timeout = (r_toCnt == TOW'(TIMEOUT - 1));
  assign err       = r_err;
  assign pfx_ivec  = r_lanes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Strobes and addresses are decoded from state so reset silences them immediately.
  always_comb begin
    w_next       = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    pfx_valid_in = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = (num_vec == '0) ? DONE : LOAD;
      end
      LOAD: begin
        rd_en   = 1'b1;
        rd_addr = r_rdPtr;
        if (w_lastIdx) w_next = DRAIN;
      end
      DRAIN: w_next = ISSUE;
      ISSUE: begin
        pfx_valid_in = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (pfx_valid_out)  w_next = STORE;
        else if (w_timeout) w_next = DONE;
      end
      STORE: begin
        wr_en   = 1'b1;
        wr_addr = r_wrPtr;
        wr_data = r_result[int'(r_idx)*IWIDTH +: IWIDTH];
        if (w_lastIdx) w_next = w_lastVec ? DONE : LOAD;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Read data lands one cycle after its strobe, so capture lags the read index by one.
  // The pointers run continuously across vectors, giving base + v*V_LEN + i without a multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_numVec   <= '0;
      r_vecCnt   <= '0;
      r_idx      <= '0;
      r_capIdx   <= '0;
      r_capValid <= 1'b0;
      r_toCnt    <= '0;
      r_err      <= 1'b0;
      r_lanes    <= '0;
      r_result   <= '0;
    end else begin
      r_capValid <= (r_state == LOAD);
      r_capIdx   <= r_idx;
      if (r_capValid) r_lanes[int'(r_capIdx)*IWIDTH +: IWIDTH] <= rd_data;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rdPtr  <= src_addr;
            r_wrPtr  <= dst_addr;
            r_numVec <= num_vec;
            r_vecCnt <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
          end
        end
        LOAD: begin
          r_rdPtr <= r_rdPtr + AWIDTH'(1);
          r_idx   <= w_lastIdx ? '0 : r_idx + IDXW'(1);
        end
        ISSUE: r_toCnt <= '0;
        WAIT: begin
          if (pfx_valid_out)  r_result <= pfx_ovec;
          else if (w_timeout) r_err    <= 1'b1;
          else                r_toCnt  <= r_toCnt + TOW'(1);
        end
        STORE: begin
          r_wrPtr <= r_wrPtr + AWIDTH'(1);
          r_idx   <= w_lastIdx ? '0 : r_idx + IDXW'(1);
          if (w_lastIdx) r_vecCnt <= w_vecNext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pfxsum_ctrl.sv
// Directed bench for pfxsum_ctrl: behavioural memory and prefix-sum model, with a
// scoreboard of expected read addresses and writes filled when each job is started.
module tb_pfxsum_ctrl;
  localparam int IW = 8;
  localparam int VL = 8;
  localparam int AW = 8;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     src_addr = '0;
  logic [AW-1:0]     dst_addr = '0;
  logic [AW-1:0]     num_vec = '0;
  logic              busy, done, err, rd_en, wr_en, pfx_valid_in;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [IW-1:0]     rd_data = '0;
  logic [IW-1:0]     wr_data;
  logic [IW*VL-1:0]  pfx_ivec;
  logic              pfx_valid_out = 1'b0;
  logic [IW*VL-1:0]  pfx_ovec = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wrExp_t;

  logic [AW-1:0] rdQ[$];
  wrExp_t        wrQ[$];
  logic [IW-1:0] srcMem [0:255];

  int nAsserts = 0;
  int nFails = 0;
  int negCount = 0;
  int rdCnt = 0, wrCnt = 0, pviCnt = 0, doneCnt = 0, overlapCnt = 0;
  int pviCycle = -1, doneCycle = -1, errRiseCycle = -1, acceptNeg = 0;
  logic errPrev = 1'b0;

  int               mdlLatency = 3;
  bit               mdlOn = 1'b1;
  int               mdlCnt = 0;
  logic [IW*VL-1:0] mdlVec = '0;

  pfxsum_ctrl #(.IWIDTH(IW), .V_LEN(VL), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pfx_valid_in(pfx_valid_in), .pfx_ivec(pfx_ivec),
    .pfx_valid_out(pfx_valid_out), .pfx_ovec(pfx_ovec)
  );

  always #5 clk = ~clk;

  function automatic logic [IW*VL-1:0] prefixSum(input logic [IW*VL-1:0] v);
    logic [IW*VL-1:0] r;
    logic [IW-1:0]    acc;
    r = '0;
    acc = '0;
    for (int i = 0; i < VL; i++) begin
      acc = acc + v[i*IW +: IW];
      r[i*IW +: IW] = acc;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= srcMem[rd_addr];
  end

  // Prefix-sum unit model: answers mdlLatency cycles after the issue pulse, or never when disabled.
  always @(posedge clk) begin
    if (rst) begin
      pfx_valid_out <= 1'b0;
      pfx_ovec      <= '0;
      mdlCnt        <= 0;
    end else begin
      pfx_valid_out <= 1'b0;
      if (pfx_valid_in && mdlOn) begin
        mdlVec <= prefixSum(pfx_ivec);
        mdlCnt <= mdlLatency;
      end else if (mdlCnt > 0) begin
        mdlCnt <= mdlCnt - 1;
        if (mdlCnt == 1) begin
          pfx_valid_out <= 1'b1;
          pfx_ovec      <= mdlVec;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reportUnexpected(input string tag, input logic [63:0] obs);
    nAsserts++;
    nFails++;
    $error("[TB] FAIL %s: observed strobe at addr 0x%0h, expected none", tag, obs);
  endtask

  // Monitor: pops the scoreboard on every strobe and timestamps pulses by falling-edge count.
  always @(negedge clk) begin
    wrExp_t e;
    negCount++;
    if (!rst) begin
      if (rd_en && wr_en) overlapCnt++;
      if (rd_en) begin
        rdCnt++;
        if (rdQ.size() == 0) reportUnexpected("rd_unexpected", 64'(rd_addr));
        else checkOutput("rd_addr", 64'(rd_addr), 64'(rdQ.pop_front()));
      end
      if (wr_en) begin
        wrCnt++;
        if (wrQ.size() == 0) reportUnexpected("wr_unexpected", 64'(wr_addr));
        else begin
          e = wrQ.pop_front();
          checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
          checkOutput("wr_data", 64'(wr_data), 64'(e.data));
        end
      end
      if (pfx_valid_in) begin
        pviCnt++;
        pviCycle = negCount;
      end
      if (done) begin
        doneCnt++;
        doneCycle = negCount;
      end
      if (err && !errPrev) errRiseCycle = negCount;
    end
    errPrev = err;
  end

  task automatic applyStimulus(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                               input logic [AW-1:0] nv, input bit expectWrites);
    logic [IW-1:0] acc;
    logic [AW-1:0] a;
    wrExp_t        e;
    int            nRd;
    rdCnt = 0; wrCnt = 0; pviCnt = 0; doneCnt = 0; overlapCnt = 0;
    pviCycle = -1; doneCycle = -1; errRiseCycle = -1;
    nRd = expectWrites ? int'(nv) : ((nv == 0) ? 0 : 1);
    for (int k = 0; k < nRd; k++)
      for (int i = 0; i < VL; i++) begin
        a = src + AW'(k*VL + i);
        rdQ.push_back(a);
      end
    if (expectWrites)
      for (int k = 0; k < int'(nv); k++) begin
        acc = '0;
        for (int i = 0; i < VL; i++) begin
          a = src + AW'(k*VL + i);
          acc = acc + srcMem[a];
          e.addr = dst + AW'(k*VL + i);
          e.data = acc;
          wrQ.push_back(e);
        end
      end
    @(posedge clk); #1;
    start = 1'b1; src_addr = src; dst_addr = dst; num_vec = nv;
    @(posedge clk); #1;
    start = 1'b0; src_addr = 8'hA5; dst_addr = 8'h5A; num_vec = 8'h77;
    acceptNeg = negCount;
  endtask

  task automatic finishJob(input string tag, input int budget, input logic expErr, input int expPvi);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done_count"}, 64'(doneCnt), 64'd1);
    checkOutput({tag, "_rdq_left"}, 64'(rdQ.size()), 64'd0);
    checkOutput({tag, "_wrq_left"}, 64'(wrQ.size()), 64'd0);
    checkOutput({tag, "_rd_wr_overlap"}, 64'(overlapCnt), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
    checkOutput({tag, "_pvi_count"}, 64'(pviCnt), 64'(expPvi));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IW*VL-1:0] expVec;
    bit               found;

    for (int i = 0; i < 256; i++) srcMem[i] = '0;
    for (int i = 0; i < 8; i++) srcMem[i] = IW'(i + 1);
    for (int i = 0; i < 8; i++) srcMem[248 + i] = IW'(8'h10 * i + 3);
    for (int i = 0; i < 8; i++) srcMem[64 + i] = IW'($urandom_range(0, 255));

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_strobes", 64'({done, err, rd_en, wr_en, pfx_valid_in}), 64'd0);
    checkOutput("rst_pfx_ivec", 64'(pfx_ivec), 64'd0);
    rst = 1'b0;

    $display("[TB] single vector");
    applyStimulus(8'd0, 8'd16, 8'd1, 1'b1);
    finishJob("single", 100, 1'b0, 1);
    checkOutput("single_issue_latency", 64'(pviCycle - acceptNeg), 64'd10);
    checkOutput("single_wr_count", 64'(wrCnt), 64'd8);
    for (int i = 0; i < VL; i++) expVec[i*IW +: IW] = srcMem[i];
    checkOutput("single_ivec_hold", 64'(pfx_ivec), 64'(expVec));

    $display("[TB] multi-vector wrap");
    mdlLatency = 1;
    applyStimulus(8'd248, 8'd240, 8'd2, 1'b1);
    finishJob("wrap", 200, 1'b0, 2);
    checkOutput("wrap_rd_count", 64'(rdCnt), 64'd16);
    checkOutput("wrap_wr_count", 64'(wrCnt), 64'd16);

    $display("[TB] timeout");
    mdlOn = 1'b0;
    applyStimulus(8'd0, 8'd16, 8'd3, 1'b0);
    finishJob("tmo", 800, 1'b1, 1);
    checkOutput("tmo_err_delay", 64'(errRiseCycle - pviCycle), 64'd256);
    checkOutput("tmo_done_with_err", 64'(doneCycle - errRiseCycle), 64'd0);
    checkOutput("tmo_wr_count", 64'(wrCnt), 64'd0);
    checkOutput("tmo_rd_count", 64'(rdCnt), 64'd8);
    repeat (5) @(negedge clk);
    checkOutput("tmo_err_sticky", 64'(err), 64'd1);
    mdlOn = 1'b1;

    $display("[TB] empty job");
    applyStimulus(8'd3, 8'd9, 8'd0, 1'b1);
    checkOutput("nv0_err_cleared", 64'(err), 64'd0);
    finishJob("nv0", 20, 1'b0, 0);
    checkOutput("nv0_done_latency", 64'(doneCycle - acceptNeg), 64'd1);
    checkOutput("nv0_rd_count", 64'(rdCnt), 64'd0);
    checkOutput("nv0_wr_count", 64'(wrCnt), 64'd0);

    $display("[TB] start while busy");
    mdlLatency = 4;
    applyStimulus(8'd64, 8'd128, 8'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; src_addr = 8'd0; dst_addr = 8'd50; num_vec = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("ign_store_reached", 64'(found), 64'd1);
    start = 1'b1; src_addr = 8'd0; dst_addr = 8'd50; num_vec = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    finishJob("ign", 100, 1'b0, 1);
    checkOutput("ign_wr_count", 64'(wrCnt), 64'd8);
    repeat (4) @(negedge clk);
    checkOutput("ign_stays_idle", 64'(busy), 64'd0);

    $display("[TB] reset during store");
    mdlLatency = 2;
    applyStimulus(8'd0, 8'd16, 8'd1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (wrCnt == 3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rstmid_three_writes", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_strobes", 64'({wr_en, rd_en, pfx_valid_in, done}), 64'd0);
    checkOutput("rstmid_busy", 64'(busy), 64'd0);
    checkOutput("rstmid_pfx_ivec", 64'(pfx_ivec), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstmid_wr_count", 64'(wrCnt), 64'd3);
    checkOutput("rstmid_rdq_left", 64'(rdQ.size()), 64'd0);
    wrQ.delete();
    applyStimulus(8'd0, 8'd16, 8'd1, 1'b1);
    finishJob("after_rst", 100, 1'b0, 1);
    checkOutput("after_rst_wr_count", 64'(wrCnt), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
